// File: rtl/debouncer_bank_pkg.sv
// rtl/debouncer_bank_pkg.sv - shared constants and types for the debouncer bank
package debouncer_bank_pkg;

  localparam int unsigned CHANNELS_DEFAULT      = 4;
  localparam int unsigned STABLE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/debouncer_bank_channel.sv
// rtl/debouncer_bank_channel.sv - one channel: 2-flop sync, stability counter, level and edge pulses
module debounce_channel
  import debouncer_bank_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pb_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, fall_q;
  edge_e         edge_d;

  // Acceptance happens on the increment that would reach STABLE_CYCLES,
  // so the counter itself never holds that value and cannot wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    edge_d  = EDGE_NONE;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST_CNT) begin
        level_d = ~level_q;
        cnt_d   = '0;
        edge_d  = level_q ? EDGE_FALL : EDGE_RISE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= (edge_d == EDGE_RISE);
      fall_q  <= (edge_d == EDGE_FALL);
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - bank of independent debounced button/sensor channels
module debouncer_bank
  import debouncer_bank_pkg::*;
#(
  parameter int unsigned CHANNELS      = CHANNELS_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_level,
  output logic [CHANNELS-1:0] pb_rise,
  output logic [CHANNELS-1:0] pb_fall
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_ch (
      .clk_i   (clk),
      .rst_i   (rst),
      .tick_i  (tick),
      .pb_i    (pb_in[g]),
      .level_o (pb_level[g]),
      .rise_o  (pb_rise[g]),
      .fall_o  (pb_fall[g])
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb/tb_debouncer_bank.sv - randomized and directed self-checking bench for debouncer_bank
module tb_debouncer_bank;

  localparam int CH = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b1;
  logic [CH-1:0] pb_in = '0;
  logic [CH-1:0] pb_level, pb_rise, pb_fall;

  int errors = 0;
  int checks = 0;

  debouncer_bank #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pb_in    (pb_in),
    .pb_level (pb_level),
    .pb_rise  (pb_rise),
    .pb_fall  (pb_fall)
  );

  always #5 clk = ~clk;

  // Reference: the channel sees pb_in two clocks late; a run of STABLE_CYCLES
  // consecutive tick-samples differing from the accepted level flips it.
  logic [CH-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  int            m_run [CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (m_s2[c] == m_level[c]) begin
          m_run[c] = 0;
        end else if (tick) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == SC) begin
            m_level[c] = ~m_level[c];
            m_run[c]   = 0;
            m_rise[c]  = m_level[c];
            m_fall[c]  = ~m_level[c];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = pb_in;
    end
  end

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; pb_in = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      checks++;
      if (pb_level !== '0 || pb_rise !== '0 || pb_fall !== '0) begin
        errors++;
        $display("FAIL reset i=%0d level=%b rise=%b fall=%b required all 0", i, pb_level, pb_rise, pb_fall);
      end
    end
  endtask

  task automatic test_latency();
    pb_in[0] = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (pb_level !== m_level || pb_rise !== m_rise || pb_fall !== m_fall) begin
        errors++;
        $display("FAIL latency_model i=%0d level=%b/%b rise=%b/%b fall=%b/%b", i, pb_level, m_level, pb_rise, m_rise, pb_fall, m_fall);
      end
      if (i == 4) begin
        checks++;
        if (pb_level[0] !== 1'b0) begin
          errors++; $display("FAIL latency_early level0=%b required 0", pb_level[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if (pb_level[0] !== 1'b1 || pb_rise[0] !== 1'b1) begin
          errors++; $display("FAIL latency_edge level0=%b rise0=%b required 1 1", pb_level[0], pb_rise[0]);
        end
      end
      if (i == 6) begin
        checks++;
        if (pb_rise[0] !== 1'b0 || pb_level[0] !== 1'b1) begin
          errors++; $display("FAIL latency_pulse_width rise0=%b level0=%b required 0 1", pb_rise[0], pb_level[0]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    int rise_at = -1;
    for (int i = 0; i < 20; i++) begin
      pb_in[1] = (i < 4) ? ((i % 2) == 0) : 1'b1;
      @(negedge clk);
      if (pb_rise[1]) begin rises++; if (rise_at < 0) rise_at = i; end
      checks++;
      if (pb_level !== m_level || pb_rise !== m_rise || pb_fall !== m_fall) begin
        errors++;
        $display("FAIL bounce_model i=%0d level=%b/%b rise=%b/%b", i, pb_level, m_level, pb_rise, m_rise);
      end
    end
    checks++;
    if (rises !== 1 || rise_at !== 9) begin
      errors++; $display("FAIL bounce_pulse count=%0d at=%0d required 1 at 9", rises, rise_at);
    end
  endtask

  task automatic test_tick_div();
    int rises = 0;
    int cyc = 0;
    pb_in[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick = ((cyc++ % 4) == 0);
      @(negedge clk);
      if (pb_rise[3]) rises++;
    end
    tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (pb_level[3] !== 1'b0 || pb_rise[3] !== 1'b0) begin
        errors++; $display("FAIL tick_freeze i=%0d level3=%b rise3=%b required 0 0", i, pb_level[3], pb_rise[3]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick = ((cyc++ % 4) == 0);
      @(negedge clk);
      if (pb_rise[3]) rises++;
      checks++;
      if (pb_level !== m_level || pb_rise !== m_rise || pb_fall !== m_fall) begin
        errors++;
        $display("FAIL tick_model i=%0d level=%b/%b rise=%b/%b", i, pb_level, m_level, pb_rise, m_rise);
      end
    end
    tick = 1'b1;
    checks++;
    if (rises !== 1 || pb_level[3] !== 1'b1) begin
      errors++; $display("FAIL tick_accept rises=%0d level3=%b required 1 1", rises, pb_level[3]);
    end
  endtask

  task automatic test_simul_fall();
    pb_in = 4'b1111;
    repeat (10) @(negedge clk);
    pb_in = 4'b1010;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (pb_fall !== ((i == 5) ? 4'b0101 : 4'b0000) || pb_rise !== 4'b0000) begin
        errors++; $display("FAIL simul_fall i=%0d fall=%b rise=%b required fall=%b rise=0000", i, pb_fall, pb_rise, (i == 5) ? 4'b0101 : 4'b0000);
      end
    end
    checks++;
    if (pb_level !== 4'b1010) begin
      errors++; $display("FAIL simul_fall_level level=%b required 1010", pb_level);
    end
  endtask

  task automatic test_reset_mid();
    pb_in = '0;
    repeat (10) @(negedge clk);
    pb_in[0] = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (pb_level !== '0 || pb_rise !== '0 || pb_fall !== '0) begin
        errors++; $display("FAIL reset_mid_pre i=%0d level=%b rise=%b required 0", i, pb_level, pb_rise);
      end
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checks++;
      if (pb_level[0] !== (j >= 6) || pb_rise[0] !== (j == 6)) begin
        errors++; $display("FAIL reset_mid_post j=%0d level0=%b rise0=%b required %0d %0d", j, pb_level[0], pb_rise[0], j >= 6, j == 6);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) pb_in[c] = ~pb_in[c];
      tick = ($urandom_range(0, 2) != 0);
      rst  = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      checks++;
      if (pb_level !== m_level || pb_rise !== m_rise || pb_fall !== m_fall) begin
        errors++;
        $display("FAIL random i=%0d level=%b/%b rise=%b/%b fall=%b/%b", i, pb_level, m_level, pb_rise, m_rise, pb_fall, m_fall);
      end
      checks++;
      if ((pb_rise & pb_fall) !== '0) begin
        errors++; $display("FAIL random_exclusive i=%0d rise=%b fall=%b required disjoint", i, pb_rise, pb_fall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_tick_div();
    test_simul_fall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
